mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one instruction/data memory port between the fetch stage (port I) and the load/store unit (port D).
- All three interfaces use the req/gnt/rvalid protocol:
  - req is held until gnt.
  - The address may change the cycle after gnt.
  - rvalid returns in request order.
- Tracks outstanding transactions in an owner FIFO so each response is routed back to the requester that issued it.

Parameters:
- WORD_WIDTH, 32, address/data width.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (owner FIFO depth, ≥1).
- STARVE_LIMIT, 4, consecutive cycles port I may lose arbitration before it is forced to win (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  WORD_WIDTH  fetch address
- instr_gnt_o  out  1  fetch request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  WORD_WIDTH  fetch response data
- data_req_i  in  1  LSU request
- data_addr_i  in  WORD_WIDTH  LSU address
- data_we_i  in  1  LSU write enable
- data_be_i  in  WORD_WIDTH/8  LSU byte enables
- data_wdata_i  in  WORD_WIDTH  LSU write data
- data_gnt_o  out  1  LSU request accepted
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  WORD_WIDTH  LSU response data
- mem_req_o  out  1  memory request
- mem_addr_o  out  WORD_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  WORD_WIDTH/8  memory byte enables
- mem_wdata_o  out  WORD_WIDTH  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  WORD_WIDTH  memory response data

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. While rst_n=0 at a posedge:
  - FSM goes to IDLE; owner FIFO is emptied; starve counter is cleared.
  - All outputs are 0 the cycle after.
  - Reset mid-transaction discards outstanding entries; later stray rvalid is handled as below.
- FSM states:
  - IDLE: arbitrate combinationally.
  - WAIT_GNT: owner is locked.
  - IDLE→WAIT_GNT when mem_req_o=1 and mem_gnt_i=0.
  - WAIT_GNT→IDLE when mem_gnt_i=1.
  - In WAIT_GNT the locked owner's fields drive mem_*; the other port cannot win.
- Arbitration in IDLE:
  - Only one requester: that one wins.
  - Both requesting: D wins, unless starve_cnt==STARVE_LIMIT, in which case I wins.
- mem_req_o = (winner's req) and (outstanding count < MAX_OUTSTANDING).
  - Count is registered; a same-cycle rvalid does not free a slot for that cycle.
- Field muxing:
  - I wins: mem_addr_o=instr_addr_i, mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
  - D wins: mem_* = data_*.
  - No request: mem_addr_o/we/be/wdata=0.
- Grants: x_gnt_o = mem_gnt_i & mem_req_o & (winner==x); combinational, same cycle as mem_gnt_i.
  - On a grant, the owner ID is pushed into the FIFO.
- Responses: on mem_rvalid_i with FIFO non-empty, the head is popped.
  - rvalid is routed to the head owner's x_rvalid_o (combinational, same cycle).
  - mem_rdata_i drives the owner's rdata; the other port's rdata is 0.
  - mem_rvalid_i with FIFO empty is dropped (no rvalid out); a simulation assertion fires.
- Push and pop in the same cycle are both performed, and the count is unchanged.
  - rvalid for a transaction is never in the same cycle as its own gnt (memory latency ≥1).
- Starve counter:
  - +1 per cycle with instr_req_i=1 and instr_gnt_o=0 while data_gnt_o=1.
  - Saturates at STARVE_LIMIT.
  - Cleared on instr_gnt_o=1 or instr_req_i=0.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_instr_cnt_o, perf_data_cnt_o, perf_full_stall_cnt_o (32 bit, reset 0, wrap at 2^32).
  - perf_instr_cnt_o / perf_data_cnt_o increment on instr_gnt_o / data_gnt_o respectively.
  - perf_full_stall_cnt_o increments on any cycle with a request pending while the FIFO is full.
- Undefined: the ports and counters are absent; arbitration is identical.

Test Plan:
- Reset then instr_req_i=1, addr 0x100, mem_gnt_i=1:
  - instr_gnt_o=1 same cycle, mem_we_o=0, mem_be_o=0xF.
  - rvalid with rdata 0xDEADBEEF 2 cycles later → instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0.
- Both requesting continuously, mem_gnt_i=1, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- D request, mem_gnt_i=0 for 3 cycles, then instr_req_i rises → mem_addr_o stays data_addr_i until gnt; no instr_gnt_o during WAIT_GNT.
- MAX_OUTSTANDING=2, grants for I then D, no rvalid:
  - third request sees mem_req_o=0.
  - next two rvalids route to I then D; mem_req_o reasserts the cycle after the first rvalid.
- mem_rvalid_i pulse with FIFO empty, and rst_n=0 asserted with 2 outstanding → no x_rvalid_o; FIFO count 0 after reset.
- MEM_ARB_PERF_EN: 3 I grants, 5 D grants, 2 full-stall cycles → counters read 3, 5, 2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and LSU (D) and routes responses back via an owner FIFO.
// Latency: grants and response routing are combinational (same cycle as mem_gnt_i / mem_rvalid_i).
// Backpressure: mem_req_o drops while MAX_OUTSTANDING transactions are pending; an ungranted request locks its owner.
// Optional: define MEM_ARB_PERF_EN to add grant and full-stall performance counters.
module mem_port_arbiter #(
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req_i,
  input  logic [WORD_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [WORD_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [WORD_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [WORD_WIDTH/8-1:0] data_be_i,
  input  logic [WORD_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [WORD_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [WORD_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [WORD_WIDTH/8-1:0] mem_be_o,
  output logic [WORD_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_instr_cnt_o,
  output logic [31:0]             perf_data_cnt_o,
  output logic [31:0]             perf_full_stall_cnt_o
`endif
);

  localparam int unsigned BE_W  = WORD_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_GNT = 1'b1;

  // Owner encoding used throughout: 0 = fetch (I), 1 = LSU (D).
  logic [0:0]                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [STV_W-1:0]           starve_q, starve_d;
  logic [MAX_OUTSTANDING-1:0] own_q;

  logic sel_vld;
  logic sel_data;
  logic sel_req;
  logic slot_free;
  logic push;
  logic pop;
  logic fifo_empty;
  logic head_data;

  // Pick the winner: locked owner while waiting for gnt, otherwise D over I unless I has starved.
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = 1'b0;
    if (state_q == WAIT_GNT) begin
      sel_vld  = 1'b1;
      sel_data = owner_q;
    end else if (data_req_i && instr_req_i) begin
      sel_vld  = 1'b1;
      sel_data = (starve_q != STV_MAX);
    end else if (data_req_i) begin
      sel_vld  = 1'b1;
      sel_data = 1'b1;
    end else if (instr_req_i) begin
      sel_vld  = 1'b1;
      sel_data = 1'b0;
    end
  end

  assign sel_req    = sel_data ? data_req_i : instr_req_i;
  assign slot_free  = (cnt_q < MAX_CNT);
  assign mem_req_o  = sel_vld & sel_req & slot_free;
  assign fifo_empty = (cnt_q == '0);

  // Drive the memory request fields from the winner; fetches are always full-word reads.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (sel_vld && sel_data) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else if (sel_vld) begin
      mem_addr_o  = instr_addr_i;
      mem_be_o    = {BE_W{1'b1}};
    end
  end

  assign instr_gnt_o = mem_gnt_i & mem_req_o & ~sel_data;
  assign data_gnt_o  = mem_gnt_i & mem_req_o & sel_data;

  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~fifo_empty;
  assign head_data = own_q[rd_ptr_q];

  assign instr_rvalid_o = pop & ~head_data;
  assign data_rvalid_o  = pop & head_data;
  assign instr_rdata_o  = (pop && !head_data) ? mem_rdata_i : '0;
  assign data_rdata_o   = (pop && head_data)  ? mem_rdata_i : '0;

  // Lock the owner when the memory stalls a request, release on gnt.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = WAIT_GNT;
          owner_d = sel_data;
        end
      end
      WAIT_GNT: begin
        if (mem_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner FIFO bookkeeping: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  // Count cycles I loses to a D grant; saturate so I is forced through at the limit.
  always_comb begin
    starve_d = starve_q;
    if (instr_gnt_o || !instr_req_i) begin
      starve_d = '0;
    end else if (data_gnt_o && (starve_q != STV_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
      own_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
      if (push) begin
        own_q[wr_ptr_q] <= sel_data;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_instr_cnt_o      <= '0;
      perf_data_cnt_o       <= '0;
      perf_full_stall_cnt_o <= '0;
    end else begin
      if (instr_gnt_o) perf_instr_cnt_o <= perf_instr_cnt_o + 32'd1;
      if (data_gnt_o)  perf_data_cnt_o  <= perf_data_cnt_o + 32'd1;
      if ((instr_req_i || data_req_i) && (cnt_q == MAX_CNT)) begin
        perf_full_stall_cnt_o <= perf_full_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is dropped; flag it in simulation.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(mem_rvalid_i && fifo_empty))
        else $warning("mem_port_arbiter: mem_rvalid_i with no outstanding transaction, response dropped");
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for the I/D memory port arbiter.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
// Expected values are hand-computed for WORD_WIDTH=32, MAX_OUTSTANDING=2, STARVE_LIMIT=4.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_instr_cnt_o;
  logic [31:0] perf_data_cnt_o;
  logic [31:0] perf_full_stall_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .WORD_WIDTH(32), .MAX_OUTSTANDING(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_instr_cnt_o(perf_instr_cnt_o), .perf_data_cnt_o(perf_data_cnt_o),
    .perf_full_stall_cnt_o(perf_full_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_addr_i  = '0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, mem_req_o, 1'b0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    check({tag, "_igv"}, {instr_gnt_o, instr_rvalid_o}, 2'b00);
    check({tag, "_dgv"}, {data_gnt_o, data_rvalid_o}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check_quiet("reset");

    // Single fetch granted immediately, answered two cycles later.
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
    #1;
    check("t1_ignt", instr_gnt_o, 1'b1);
    check("t1_addr", mem_addr_o, 32'h100);
    check("t1_we_be", {mem_we_o, mem_be_o}, 5'b0_1111);
    tick();
    idle_inputs();
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    check("t1_irv", instr_rvalid_o, 1'b1);
    check("t1_irdata", instr_rdata_o, 32'hDEADBEEF);
    check("t1_drv", {data_rvalid_o, data_rdata_o}, 33'h0);
    tick();
    idle_inputs();

    // Both requesting: D,D,D,D,I repeated; responses returned every cycle after the first grant.
    for (int k = 0; k < 10; k++) begin
      tick();
      instr_req_i = 1'b1; instr_addr_i = 32'h1000;
      data_req_i = 1'b1; data_addr_i = 32'h2000;
      mem_gnt_i = 1'b1;
      mem_rvalid_i = (k > 0); mem_rdata_i = k;
      #1;
      check($sformatf("t2_gnt%0d", k), {instr_gnt_o, data_gnt_o}, (k % 5 == 4) ? 2'b10 : 2'b01);
      if (k > 0) begin
        check($sformatf("t2_rv%0d", k), {instr_rvalid_o, data_rvalid_o},
              ((k - 1) % 5 == 4) ? 2'b10 : 2'b01);
      end
    end
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    #1;
    check("t2_last_irv", instr_rvalid_o, 1'b1);
    tick();
    idle_inputs();

    // D stalled in WAIT_GNT; a later I request must not steal the port.
    for (int c = 0; c < 6; c++) begin
      tick();
      data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1;
      data_be_i = 4'h3; data_wdata_i = 32'h55;
      instr_req_i = (c >= 3); instr_addr_i = 32'h300;
      mem_gnt_i = (c == 5);
      #1;
      check($sformatf("t3_addr%0d", c), mem_addr_o, 32'h200);
      check($sformatf("t3_gnt%0d", c), {instr_gnt_o, data_gnt_o}, (c == 5) ? 2'b01 : 2'b00);
    end
    tick();
    data_req_i = 1'b0; data_we_i = 1'b0;
    #1;
    check("t3_igrant", instr_gnt_o, 1'b1);
    check("t3_iaddr", {mem_addr_o, mem_we_o, mem_be_o}, {32'h300, 1'b0, 4'hF});
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    #1;
    check("t3_rv_first_d", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    tick();
    #1;
    check("t3_rv_then_i", {instr_rvalid_o, data_rvalid_o}, 2'b10);
    tick();
    idle_inputs();

    // Outstanding limit: two grants fill the FIFO; third request waits for a response.
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
    #1;
    check("t4_igrant", instr_gnt_o, 1'b1);
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h500;
    #1;
    check("t4_dgrant", data_gnt_o, 1'b1);
    tick();
    data_addr_i = 32'h600;
    #1;
    check("t4_full_req", {mem_req_o, data_gnt_o}, 2'b00);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA1;
    #1;
    check("t4_rv1", {instr_rvalid_o, instr_rdata_o}, {1'b1, 32'hA1});
    check("t4_still_full", mem_req_o, 1'b0);
    tick();
    mem_rdata_i = 32'hA2;
    #1;
    check("t4_rv2", {data_rvalid_o, data_rdata_o, instr_rvalid_o}, {1'b1, 32'hA2, 1'b0});
    check("t4_reassert", {mem_req_o, data_gnt_o}, 2'b11);
    tick();
    data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'hA3;
    #1;
    check("t4_rv3", {data_rvalid_o, data_rdata_o}, {1'b1, 32'hA3});
    tick();
    idle_inputs();

`ifdef MEM_ARB_PERF_EN
    #1;
    check("perf_instr", perf_instr_cnt_o, 32'd5);
    check("perf_data", perf_data_cnt_o, 32'd11);
    check("perf_stall", perf_full_stall_cnt_o, 32'd2);
`endif

    // Stray response with nothing outstanding is dropped.
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
    #1;
    check("t5_stray", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    // Two outstanding, then reset discards them.
    tick();
    idle_inputs();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b1;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check_quiet("t5_reset");
`ifdef MEM_ARB_PERF_EN
    check("t5_perf_clr", {perf_instr_cnt_o, perf_data_cnt_o, perf_full_stall_cnt_o}, 96'h0);
`endif
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
    #1;
    check("t5_post_reset_stray", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    tick();
    idle_inputs();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    #1;
    check("t5_slot1", {mem_req_o, instr_gnt_o}, 2'b11);
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b1;
    #1;
    check("t5_slot2", {mem_req_o, data_gnt_o}, 2'b11);
    tick();
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
